// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the game frame scheduler.
// Holds the FSM encoding, phase indices and the period helper.
package frame_sched_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int PH_PLAYER  = 0;
   localparam int PH_BULLET  = 1;
   localparam int PH_ENEMY   = 2;
   localparam int PH_COLLIDE = 3;

   localparam int DEF_BASE_TICK_CYCLES = 5_000_000;
   localparam int DEF_N_PHASE          = 4;
   localparam int DEF_TIMEOUT_CYCLES   = 1024;
   localparam int DEF_FRAME_W          = 16;

   // A one-cycle period would make tick a constant level, so two is the floor.
   function automatic logic [31:0] calc_period(input logic [31:0] base, input logic [1:0] speed);
      logic [31:0] p;
      p = base >> speed;
      if (p < 32'd2) p = 32'd2;
      return p;
   endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Control/status bundle between the frame scheduler and the game subsystems.
// The master side drives run controls and phase_done; the slave side is the scheduler.
interface frame_scheduler_if #(
   parameter int N_PHASE = 4,
   parameter int FRAME_W = 16
);
   logic               enable;
   logic               pause;
   logic [1:0]         speed;
   logic [N_PHASE-1:0] phase_done;
   logic [N_PHASE-1:0] phase_req;
   logic               tick;
   logic               frame_done;
   logic               busy;
   logic [FRAME_W-1:0] frame_cnt;
   logic [7:0]         overrun_cnt;
   logic               timeout_err;

   modport master (
      output enable, pause, speed, phase_done,
      input  phase_req, tick, frame_done, busy, frame_cnt, overrun_cnt, timeout_err
   );

   modport slave (
      input  enable, pause, speed, phase_done,
      output phase_req, tick, frame_done, busy, frame_cnt, overrun_cnt, timeout_err
   );
endinterface

// File: rtl/frame_scheduler_tick_gen.sv
// Programmable game-tick divider: tick is a combinational pulse in the cycle cnt==period-1.
// speed is latched only on wrap or while disabled, so a mid-period change applies next period.
module tick_gen
   import frame_sched_pkg::*;
#(
   parameter int BASE_TICK_CYCLES = DEF_BASE_TICK_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       pause,
   input  logic [1:0] speed,
   output logic       tick
);

   localparam logic [31:0] BASE = 32'(BASE_TICK_CYCLES);

   logic [31:0] cnt;
   logic [31:0] period;

   assign tick = !rst && enable && !pause && (cnt == period - 32'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= 32'd0;
         period <= calc_period(BASE, 2'd0);
      end else if (!enable) begin
         cnt    <= 32'd0;
         period <= calc_period(BASE, speed);
      end else if (tick) begin
         cnt    <= 32'd0;
         period <= calc_period(BASE, speed);
      end else if (!pause) begin
         cnt    <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: each tick walks phase_req one-hot through N_PHASE req/done phases, one cycle after the tick.
// Phases are bounded by a watchdog; ticks arriving mid-frame are dropped and counted.
module frame_scheduler
   import frame_sched_pkg::*;
#(
   parameter int BASE_TICK_CYCLES = DEF_BASE_TICK_CYCLES,
   parameter int N_PHASE          = DEF_N_PHASE,
   parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
   parameter int FRAME_W          = DEF_FRAME_W
) (
   input logic              clk,
   input logic              rst,
   frame_scheduler_if.slave bus
);

   localparam int KW   = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [KW-1:0]      K_FIRST = KW'(PH_PLAYER);
   localparam logic [KW-1:0]      K_LAST  = KW'(N_PHASE - 1);
   localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [N_PHASE-1:0] REQ_ONE = N_PHASE'(1);

   state_t              state, state_n;
   logic [KW-1:0]       k, k_n;
   logic [WD_W-1:0]     wdog, wdog_n;
   logic                frame_done_q, frame_done_n;
   logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_n;
   logic [7:0]          overrun_q, overrun_n;
   logic                terr_q, terr_n;
   logic                tick_w;
   logic                done_k;
   logic                expired;
   logic                final_exit;

   tick_gen #(
      .BASE_TICK_CYCLES(BASE_TICK_CYCLES)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (bus.enable),
      .pause  (bus.pause),
      .speed  (bus.speed),
      .tick   (tick_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         k            <= K_FIRST;
         wdog         <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         overrun_q    <= 8'd0;
         terr_q       <= 1'b0;
      end else begin
         state        <= state_n;
         k            <= k_n;
         wdog         <= wdog_n;
         frame_done_q <= frame_done_n;
         frame_cnt_q  <= frame_cnt_n;
         overrun_q    <= overrun_n;
         terr_q       <= terr_n;
      end
   end

   always_comb begin
      state_n      = state;
      k_n          = k;
      wdog_n       = wdog;
      frame_done_n = 1'b0;
      frame_cnt_n  = frame_cnt_q;
      overrun_n    = overrun_q;
      terr_n       = terr_q;
      final_exit   = 1'b0;
      done_k       = bus.phase_done[k];
      expired      = (wdog == WD_LAST);

      if (!bus.enable) begin
         state_n = ST_IDLE;
         k_n     = K_FIRST;
         wdog_n  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tick_w) begin
                  state_n = ST_RUN;
                  k_n     = K_FIRST;
                  wdog_n  = '0;
               end
            end
            ST_RUN: begin
               if (done_k || expired) begin
                  // A done arriving on the watchdog's last cycle still counts as done.
                  if (!done_k) terr_n = 1'b1;
                  wdog_n = '0;
                  if (k == K_LAST) begin
                     final_exit   = 1'b1;
                     frame_done_n = 1'b1;
                     frame_cnt_n  = frame_cnt_q + 1'b1;
                     k_n          = K_FIRST;
                     if (!tick_w) state_n = ST_IDLE;
                  end else begin
                     k_n = k + 1'b1;
                  end
               end else begin
                  wdog_n = wdog + 1'b1;
               end
               if (tick_w && !final_exit && (overrun_q != 8'hFF))
                  overrun_n = overrun_q + 8'd1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   assign bus.tick        = tick_w;
   assign bus.busy        = (state == ST_RUN);
   assign bus.phase_req   = (state == ST_RUN) ? (REQ_ONE << k) : '0;
   assign bus.frame_done  = frame_done_q;
   assign bus.frame_cnt   = frame_cnt_q;
   assign bus.overrun_cnt = overrun_q;
   assign bus.timeout_err = terr_q;

endmodule
